// File: rtl/mux_rr_n.sv
// N-channel W-bit stream multiplexer with valid/ready handshakes and a registered output.
// Selects by a fixed index (mode=0) or by round-robin starting after the last served channel (mode=1).
module mux_rr_n #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   s,
  input  logic [N-1:0]      in_valid,
  input  logic [N*W-1:0]    in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);

  logic [W-1:0]    ch_data [N];
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;

  logic            load_en;
  logic            gnt_valid;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] scan;
  logic            xfer;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

  // Round-robin scan walks ptr+1, ptr+2, ... with an explicit wrap so non-power-of-two N works.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan      = ptr_q;
    if (!mode) begin
      if (int'(s) < N) begin
        if (in_valid[s]) begin
          gnt_valid = 1'b1;
          gnt_idx   = s;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        scan = (scan == SELW'(N - 1)) ? '0 : scan + SELW'(1);
        if (!gnt_valid && in_valid[scan]) begin
          gnt_valid = 1'b1;
          gnt_idx   = scan;
        end
      end
    end
  end

  assign load_en  = !out_valid_q | out_ready;
  assign in_ready = (load_en && gnt_valid && !rst) ? (N'(1) << gnt_idx) : '0;
  assign xfer     = |in_ready;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gnt_idx];
      out_ch_d    = gnt_idx;
      ptr_d       = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= SELW'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the selection and output register.
module tb_mux_rr_n;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SELW-1:0]   s;
  logic [N-1:0]      in_valid;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_ch;
  logic              out_ready;

  mux_rr_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s(s),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] chd [N];

  // reference model state
  int m_valid = 0;
  int m_data  = 0;
  int m_ch    = 0;
  int m_ptr   = N - 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(s) < N && in_valid[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check the combinational accept strobe, clock, then check the registered output.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = chd[i];
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (!rst && g >= 0 && (m_valid == 0 || out_ready)) exp_rdy[g] = 1'b1;
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = N - 1;
    end else if (exp_rdy != 0) begin
      m_valid = 1; m_data = int'(chd[g]); m_ch = g; m_ptr = g;
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
    #1;
    cyc++;
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    check_val("out_data",  32'(out_data),  32'(m_data));
    check_val("out_ch",    32'(out_ch),    32'(m_ch));
    $display("cyc %0d rst=%0b mode=%0b s=%0d vld=%b rdy=%b -> ov=%0b od=%02h oc=%0d",
             cyc, rst, mode, s, in_valid, in_ready, out_valid, out_data, out_ch);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; s = '0; in_valid = '1; out_ready = 1'b0; in_data = '0;
    for (int i = 0; i < N; i++) chd[i] = '0;
    @(posedge clk); #1;

    // reset and idle
    cycle(); cycle();
    rst = 1'b0; in_valid = '0;
    repeat (3) cycle();
    check_val("idle_valid", 32'(out_valid), 32'd0);

    // fixed select
    chd[0] = 8'hA0; chd[1] = 8'hB1; chd[2] = 8'hC2; chd[3] = 8'hD3;
    in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [7:0] expd [4];
      expd[0] = 8'hA0; expd[1] = 8'hB1; expd[2] = 8'hC2; expd[3] = 8'hD3;
      s = SELW'(i);
      cycle();
      check_val("fix_data", 32'(out_data), 32'(expd[i]));
      check_val("fix_ch", 32'(out_ch), 32'(i));
    end
    s = 2; in_valid = 4'b1011;
    cycle();
    check_val("fix_nordy", 32'(in_ready), 32'd0);
    check_val("fix_drop", 32'(out_valid), 32'd0);

    // round-robin fairness
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_val("rr_all", 32'(out_ch), 32'(i % 4));
    end
    in_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("rr_0101", 32'(out_ch), 32'((i % 2) * 2));
    end

    // backpressure
    in_valid = 4'b0010; chd[1] = 8'h5C;
    cycle();
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("bp_data", 32'(out_data), 32'h5C);
      check_val("bp_ch", 32'(out_ch), 32'd1);
      check_val("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    check_val("bp_next", 32'(out_ch), 32'd2);

    // simultaneous drain and load
    in_valid = 4'b1000; chd[3] = 8'h77;
    cycle();
    check_val("sdl_data", 32'(out_data), 32'h77);
    check_val("sdl_ch", 32'(out_ch), 32'd3);
    check_val("sdl_valid", 32'(out_valid), 32'd1);

    // mode switch
    in_valid = 4'b0100;
    cycle();
    mode = 1'b0; s = 3; in_valid = 4'b1000;
    cycle();
    mode = 1'b1; in_valid = 4'b1111;
    cycle();
    check_val("sw_rr0", 32'(out_ch), 32'd0);

    // reset mid-stream
    rst = 1'b1;
    cycle();
    check_val("rst_mid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    cycle();
    check_val("rst_first", 32'(out_ch), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom_range(0, 1));
      s         = SELW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) chd[i] = W'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
